fpu_access_arbiter: RTL and testbench

//  Shares one Fixed_Point_Unit between two requesters (req0, req1) using round-robin

---
 rtl/fpu_access_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_fpu_access_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_access_arbiter.sv
// fpu_access_arbiter: shares one fixed-point FPU between two requesters.
// Round-robin grant in IDLE, then the FPU is driven with the latched operation
// for a per-operation hold time. The result is returned to the owner as a
// one-cycle response pulse. MUL and SQRT are followed by one flush cycle.
module fpu_access_arbiter #(
  parameter int WIDTH        = 32,
  parameter int MUL_CYCLES   = 12,
  parameter int SQRT_MIN     = 2,
  parameter int SQRT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_error,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_error,
  output logic [1:0]       fpu_operation,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             busy
);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_SQRT = 2'd3;

  localparam int CW = 16;
  localparam logic [CW-1:0] MUL_LAST  = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] SQRT_HOLD = CW'(SQRT_MIN);
  localparam logic [CW-1:0] SQRT_LAST = CW'(SQRT_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_RESP  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       fpu_op_q, fpu_op_d;
  logic [WIDTH-1:0] fpu_a_q, fpu_a_d;
  logic [WIDTH-1:0] fpu_b_q, fpu_b_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic             rsp0_error_q, rsp0_error_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic             rsp1_error_q, rsp1_error_d;

  logic grant_s;
  logic grant_id_s;
  logic done_s;
  logic err_s;

  // Grant decode: a lone requester wins, a tie goes to the pointer's requester.
  always_comb begin
    grant_s    = (state_q == S_IDLE) && (req0_valid || req1_valid);
    grant_id_s = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  end

  assign req0_ready    = grant_s && !grant_id_s;
  assign req1_ready    = grant_s && grant_id_s;
  assign busy          = (state_q != S_IDLE);
  assign fpu_operation = fpu_op_q;
  assign fpu_operand_1 = fpu_a_q;
  assign fpu_operand_2 = fpu_b_q;
  assign rsp0_valid    = rsp0_valid_q;
  assign rsp0_data     = rsp0_data_q;
  assign rsp0_error    = rsp0_error_q;
  assign rsp1_valid    = rsp1_valid_q;
  assign rsp1_data     = rsp1_data_q;
  assign rsp1_error    = rsp1_error_q;

  // Decide whether this EXEC cycle is the sampling cycle (and whether it is a timeout).
  always_comb begin
    done_s = 1'b0;
    err_s  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: done_s = 1'b1;
      // The multiply ready flag is sticky, so only the cycle count matters.
      OP_MUL: done_s = (cnt_q >= MUL_LAST);
      OP_SQRT: begin
        if ((cnt_q > SQRT_HOLD) && fpu_ready) begin
          done_s = 1'b1;
        end else if (cnt_q >= SQRT_LAST) begin
          done_s = 1'b1;
          err_s  = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: done_s = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = grant_s ? S_EXEC : S_IDLE;
      S_EXEC:  state_d = done_s ? S_RESP : S_EXEC;
      S_RESP:  state_d = ((op_q == OP_MUL) || (op_q == OP_SQRT)) ? S_FLUSH : S_IDLE;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath/outputs: latch the request, run the hold counter, capture responses.
  always_comb begin
    ptr_d        = ptr_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = '0;
    rsp0_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp0_error_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp1_data_d  = rsp1_data_q;
    rsp1_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          id_d  = grant_id_s;
          ptr_d = !grant_id_s;
          op_d  = grant_id_s ? req1_op : req0_op;
          a_d   = grant_id_s ? req1_a : req0_a;
          b_d   = grant_id_s ? req1_b : req0_b;
          cnt_d = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      S_EXEC: begin
        if (done_s) begin
          cnt_d = '0;
          if (id_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = err_s ? '0 : fpu_result;
            rsp1_error_d = err_s;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = err_s ? '0 : fpu_result;
            rsp0_error_d = err_s;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    // Outside EXEC the FPU sees ADD with zero operands, which also flushes it.
    if (state_d == S_EXEC) begin
      fpu_op_d = op_d;
      fpu_a_d  = a_d;
      fpu_b_d  = b_d;
    end else begin
      fpu_op_d = OP_ADD;
      fpu_a_d  = '0;
      fpu_b_d  = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      fpu_op_q     <= OP_ADD;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_error_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_error_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      fpu_op_q     <= fpu_op_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_error_q <= rsp0_error_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_error_q <= rsp1_error_d;
    end
  end

endmodule

// File: tb/tb_fpu_access_arbiter.sv
// Directed bench for fpu_access_arbiter with a small behavioural fixed-point FPU
// (FBITS=10): combinational ADD/SUB/MUL, SQRT ready after 5 held cycles,
// plus an override to force fpu_ready low or high.
module tb_fpu_access_arbiter;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_SQRT = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'd0, req1_op = 2'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp0_valid, rsp1_valid, rsp0_error, rsp1_error;
  logic [31:0] rsp0_data, rsp1_data;
  logic [1:0]  fpu_operation;
  logic [31:0] fpu_operand_1, fpu_operand_2, fpu_result;
  logic        fpu_ready, busy;
  logic [1:0]  frc = 2'd0;  // 0 normal, 1 force ready low, 2 force ready high

  int n_tests = 0;
  int n_fail  = 0;

  fpu_access_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_error(rsp1_error),
    .fpu_operation(fpu_operation), .fpu_operand_1(fpu_operand_1),
    .fpu_operand_2(fpu_operand_2), .fpu_result(fpu_result),
    .fpu_ready(fpu_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- FPU model ----------------
  logic [3:0]  sq_cnt;
  logic [3:0]  mul_cnt;
  logic [63:0] prod;

  function automatic logic [31:0] isqrt(input logic [63:0] x);
    logic [31:0] r;
    logic [63:0] c;
    r = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      c = {32'd0, r | (32'd1 << i)};
      if (c * c <= x) r = c[31:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq_cnt  <= 4'd0;
      mul_cnt <= 4'd0;
    end else begin
      sq_cnt  <= (fpu_operation == OP_SQRT) ? ((sq_cnt == 4'd15) ? sq_cnt : sq_cnt + 4'd1) : 4'd0;
      mul_cnt <= (fpu_operation == OP_MUL) ? ((mul_cnt == 4'd15) ? mul_cnt : mul_cnt + 4'd1) : 4'd0;
    end
  end

  always_comb begin
    prod       = {32'd0, fpu_operand_1} * {32'd0, fpu_operand_2};
    fpu_result = 32'd0;
    fpu_ready  = 1'b1;
    case (fpu_operation)
      OP_ADD:  fpu_result = fpu_operand_1 + fpu_operand_2;
      OP_SUB:  fpu_result = fpu_operand_1 - fpu_operand_2;
      OP_MUL:  begin fpu_result = prod[41:10]; fpu_ready = (mul_cnt >= 4'd3); end
      OP_SQRT: begin fpu_result = isqrt({32'd0, fpu_operand_1} << 10); fpu_ready = (sq_cnt >= 4'd4); end
      default: fpu_result = 32'd0;
    endcase
    if (frc == 2'd1) fpu_ready = 1'b0;
    if (frc == 2'd2) fpu_ready = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_err;
    int          lat;
    logic [1:0]  frc;
  } vec_t;

  vec_t vecs[11];

  // Issue one request from an idle arbiter and check ready, latency, data, error, busy.
  task automatic run_vec(input int idx, input vec_t v);
    logic own_v, oth_v, own_e;
    logic [31:0] own_d;
    frc = v.frc;
    if (v.sel) begin
      req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready_own", idx), {31'd0, v.sel ? req1_ready : req0_ready}, 32'd1);
    chk($sformatf("v%0d_ready_oth", idx), {31'd0, v.sel ? req0_ready : req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF;
    for (int c = 1; c <= v.lat + 1; c++) begin
      @(negedge clk);
      own_v = v.sel ? rsp1_valid : rsp0_valid;
      oth_v = v.sel ? rsp0_valid : rsp1_valid;
      own_d = v.sel ? rsp1_data : rsp0_data;
      own_e = v.sel ? rsp1_error : rsp0_error;
      chk($sformatf("v%0d_c%0d_rsp_valid", idx, c), {31'd0, own_v}, {31'd0, c == v.lat});
      chk($sformatf("v%0d_c%0d_rsp_other", idx, c), {31'd0, oth_v}, 32'd0);
      if (c == v.lat) begin
        chk($sformatf("v%0d_data", idx), own_d, v.exp_data);
        chk($sformatf("v%0d_error", idx), {31'd0, own_e}, {31'd0, v.exp_err});
      end
      if (c == v.lat + 1)
        chk($sformatf("v%0d_busy_after_rsp", idx), {31'd0, busy},
            {31'd0, (v.op == OP_MUL) || (v.op == OP_SQRT)});
      @(posedge clk); #1;
    end
    frc = 2'd0;
    @(negedge clk);
    chk($sformatf("v%0d_idle", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d_data_held", idx), v.sel ? rsp1_data : rsp0_data, v.exp_data);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_fpu_op"}, {30'd0, fpu_operation}, {30'd0, OP_ADD});
    chk({tag, "_fpu_a"}, fpu_operand_1, 32'd0);
    chk({tag, "_fpu_b"}, fpu_operand_2, 32'd0);
    chk({tag, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk({tag, "_rsp_error"}, {30'd0, rsp1_error, rsp0_error}, 32'd0);
    chk({tag, "_rsp0_data"}, rsp0_data, 32'd0);
    chk({tag, "_rsp1_data"}, rsp1_data, 32'd0);
    chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
  endtask

  initial begin
    int ph, who;
    vec_t mv;
    vecs[0]  = '{1'b0, OP_ADD,  32'h400,      32'hC00, 32'h1000,     1'b0, 2,  2'd0};
    vecs[1]  = '{1'b1, OP_MUL,  32'h600,      32'h800, 32'hC00,      1'b0, 13, 2'd0};
    vecs[2]  = '{1'b1, OP_MUL,  32'h600,      32'h800, 32'hC00,      1'b0, 13, 2'd0};
    vecs[3]  = '{1'b0, OP_SQRT, 32'h1000,     32'h0,   32'h800,      1'b0, 6,  2'd0};
    vecs[4]  = '{1'b0, OP_SQRT, 32'h400,      32'h0,   32'h400,      1'b0, 6,  2'd0};
    vecs[5]  = '{1'b1, OP_SUB,  32'h1000,     32'h400, 32'hC00,      1'b0, 2,  2'd0};
    vecs[6]  = '{1'b0, OP_SUB,  32'h0,        32'h400, 32'hFFFFFC00, 1'b0, 2,  2'd0};
    vecs[7]  = '{1'b1, OP_SQRT, 32'h1000,     32'h0,   32'h800,      1'b0, 4,  2'd2};
    vecs[8]  = '{1'b1, OP_SQRT, 32'h1000,     32'h0,   32'h0,        1'b1, 65, 2'd1};
    vecs[9]  = '{1'b0, OP_ADD,  32'h400,      32'hC00, 32'h1000,     1'b0, 2,  2'd0};
    vecs[10] = '{1'b1, OP_ADD,  32'hFFFFFFFF, 32'h1,   32'h0,        1'b0, 2,  2'd0};
    mv       = '{1'b0, OP_MUL,  32'h400,      32'h400, 32'h400,      1'b0, 13, 2'd0};

    // Reset state.
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Both requesters always valid with ADDs: grants alternate starting at req0.
    req0_op = OP_ADD; req0_a = 32'h1;  req0_b = 32'h2;
    req1_op = OP_ADD; req1_a = 32'h10; req1_b = 32'h20;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      ph  = cyc % 3;
      who = (cyc / 3) % 2;
      chk($sformatf("rr%0d_ready0", cyc), {31'd0, req0_ready}, {31'd0, (ph == 0) && (who == 0)});
      chk($sformatf("rr%0d_ready1", cyc), {31'd0, req1_ready}, {31'd0, (ph == 0) && (who == 1)});
      chk($sformatf("rr%0d_rsp0", cyc), {31'd0, rsp0_valid}, {31'd0, (ph == 2) && (who == 0)});
      chk($sformatf("rr%0d_rsp1", cyc), {31'd0, rsp1_valid}, {31'd0, (ph == 2) && (who == 1)});
      if (ph == 2) begin
        chk($sformatf("rr%0d_data", cyc), (who == 1) ? rsp1_data : rsp0_data,
            (who == 1) ? 32'h30 : 32'h3);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset during the 5th MUL EXEC cycle aborts with no response.
    req0_valid = 1'b1; req0_op = OP_MUL; req0_a = 32'h600; req0_b = 32'h800;
    @(negedge clk);
    chk("mr_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    chk("mr_busy_before", {31'd0, busy}, 32'd1);
    chk("mr_fpu_op_before", {30'd0, fpu_operation}, {30'd0, OP_MUL});
    reset = 1'b1;
    #1;
    chk_reset_outputs("mr_now");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mr_hold%0d_rsp", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(11, mv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
